// File: rtl/btn_director_pkg.sv
// Shared types and width helpers for the multi-channel button director.
package btn_director_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  // Bits needed to hold a count from 0 up to and including n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: 2-flop synchroniser, press/release debounce FSM, dir toggle.
// BTN_DIRECTOR_AUTOREPEAT_EN adds held-key auto-repeat pressed pulses.
module btn_chan
  import btn_director_pkg::*;
#(
  parameter int   DB_TICKS = 4,
  parameter logic INIT_DIR = 1'b1
`ifdef BTN_DIRECTOR_AUTOREPEAT_EN
  ,
  parameter int   REP_DELAY = 32,
  parameter int   REP_RATE  = 8
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic btn,
  output logic dir,
  output logic pressed,
  output logic released,
  output logic held
);

  localparam int CW = cnt_width(DB_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

  logic [1:0]    sync_q;
  logic          s;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_d, pressed_d, released_d;

`ifdef BTN_DIRECTOR_AUTOREPEAT_EN
  localparam int RW = cnt_width(max_int(REP_DELAY, REP_RATE));
  localparam logic [RW-1:0] DELAY_LAST = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REP_RATE - 1);
  logic [RW-1:0] rep_q, rep_d;
  logic          rep_first_q, rep_first_d;
`endif

  assign s = sync_q[1];

  // Valid/ready does not apply here: sclk is a qualifier, outputs are registered levels/pulses.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_d      = dir;
    pressed_d  = 1'b0;
    released_d = 1'b0;
`ifdef BTN_DIRECTOR_AUTOREPEAT_EN
    rep_d       = rep_q;
    rep_first_d = rep_first_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (s) begin
          state_d = DEB_PRESS;
          cnt_d   = '0;
        end
      end
      DEB_PRESS: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (sclk) begin
          if (cnt_q == CNT_LAST) begin
            state_d   = HELD;
            cnt_d     = '0;
            pressed_d = 1'b1;
            dir_d     = ~dir;
`ifdef BTN_DIRECTOR_AUTOREPEAT_EN
            rep_d       = '0;
            rep_first_d = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HELD: begin
        if (!s) begin
          state_d = DEB_RELEASE;
          cnt_d   = '0;
        end
`ifdef BTN_DIRECTOR_AUTOREPEAT_EN
        else if (sclk) begin
          // First repeat waits REP_DELAY ticks, later ones REP_RATE; dir is left alone.
          if (rep_q == (rep_first_q ? RATE_LAST : DELAY_LAST)) begin
            pressed_d   = 1'b1;
            rep_d       = '0;
            rep_first_d = 1'b1;
          end else begin
            rep_d = rep_q + 1'b1;
          end
        end
`endif
      end
      DEB_RELEASE: begin
        if (s) begin
          state_d = HELD;
          cnt_d   = '0;
`ifdef BTN_DIRECTOR_AUTOREPEAT_EN
          rep_d       = '0;
          rep_first_d = 1'b0;
`endif
        end else if (sclk) begin
          if (cnt_q == CNT_LAST) begin
            state_d    = IDLE;
            cnt_d      = '0;
            released_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      dir      <= INIT_DIR;
      pressed  <= 1'b0;
      released <= 1'b0;
      held     <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], btn};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir      <= dir_d;
      pressed  <= pressed_d;
      released <= released_d;
      held     <= (state_d == HELD) || (state_d == DEB_RELEASE);
    end
  end

`ifdef BTN_DIRECTOR_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_q       <= '0;
      rep_first_q <= 1'b0;
    end else begin
      rep_q       <= rep_d;
      rep_first_q <= rep_first_d;
    end
  end
`endif

endmodule

// File: rtl/btn_director_multi.sv
// NCH independent debounced buttons with direction toggle and press/release pulses.
// Define BTN_DIRECTOR_AUTOREPEAT_EN to enable held-key auto-repeat pulses.
module btn_director_multi #(
  parameter int             NCH      = 4,
  parameter int             DB_TICKS = 4,
  parameter logic [NCH-1:0] INIT_DIR = {NCH{1'b1}}
`ifdef BTN_DIRECTOR_AUTOREPEAT_EN
  ,
  parameter int             REP_DELAY = 32,
  parameter int             REP_RATE  = 8
`endif
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sclk,
  input  logic [NCH-1:0] btn,
  output logic [NCH-1:0] dir,
  output logic [NCH-1:0] pressed,
  output logic [NCH-1:0] released,
  output logic [NCH-1:0] held
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    btn_chan #(
      .DB_TICKS (DB_TICKS),
      .INIT_DIR (INIT_DIR[i])
`ifdef BTN_DIRECTOR_AUTOREPEAT_EN
      ,
      .REP_DELAY(REP_DELAY),
      .REP_RATE (REP_RATE)
`endif
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .sclk    (sclk),
      .btn     (btn[i]),
      .dir     (dir[i]),
      .pressed (pressed[i]),
      .released(released[i]),
      .held    (held[i])
    );
  end

endmodule

// File: tb/tb_btn_director_multi.sv
// Scoreboard bench for btn_director_multi: expected pulse events are queued at stimulus time.
module tb_btn_director_multi;

  logic       clk;
  logic       rst;
  logic       sclk;
  logic [3:0] btn;
  logic [3:0] dir, pressed, released, held;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int events_seen  = 0;
  int last_evt_cyc = 0;
  int phase    = 0;

  logic [11:0] exp_q[$];
  int          evt_cyc_q[$];
  logic [3:0]  dir_m;

`ifdef BTN_DIRECTOR_AUTOREPEAT_EN
  localparam int NPRESS = 5;
`else
  localparam int NPRESS = 1;
`endif

  btn_director_multi dut (
    .clk     (clk),
    .rst     (rst),
    .sclk    (sclk),
    .btn     (btn),
    .dir     (dir),
    .pressed (pressed),
    .released(released),
    .held    (held)
  );

  // clock / reset / strobe
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    sclk = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      phase = (phase + 1) % 4;
      sclk  = (phase == 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard monitor: every pulse cycle is one event {pressed, released, dir}
  initial forever begin
    logic [11:0] got, exp;
    @(negedge clk);
    if (rst && ((pressed | released) != 4'h0)) begin
      got = {pressed, released, dir};
      if (exp_q.size() == 0) begin
        check("spurious_pulse", 32'(got), 32'h0);
      end else begin
        exp = exp_q.pop_front();
        check("pulse_event", 32'(got), 32'(exp));
      end
      events_seen++;
      last_evt_cyc = cyc;
      evt_cyc_q.push_back(cyc);
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] mask);
    btn   = btn | mask;
    dir_m = dir_m ^ mask;
    exp_q.push_back({mask, 4'h0, dir_m});
  endtask

  task automatic release_btn(input logic [3:0] mask);
    btn = btn & ~mask;
    exp_q.push_back({4'h0, mask, dir_m});
  endtask

  task automatic wait_evt(input int target, input string tag);
    int k = 0;
    while (events_seen < target && k < 200) begin
      @(posedge clk);
      k++;
    end
    check(tag, 32'(events_seen >= target), 32'h1);
    step(8);
  endtask

  initial begin
    int start, t0, base;
    rst  = 1'b0;
    btn  = 4'h0;
    dir_m = 4'hF;

    // reset with random buttons
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 btn = 4'($urandom_range(0, 15));
      @(negedge clk);
      check("reset_outputs", 32'({dir, pressed, released, held}), 32'h0000F000);
    end
    btn = 4'h0;
    step(4);
    rst = 1'b1;
    step(4);
    @(negedge clk);
    check("post_reset_idle", 32'({dir, held}), 32'hF0);
    step(1);

    // clean press / release on channel 0
    start = events_seen;
    press(4'b0001);
    t0 = cyc;
    wait_evt(start + 1, "press0_seen");
    check("press0_latency", 32'((last_evt_cyc - t0 >= 15) && (last_evt_cyc - t0 <= 23)), 32'h1);
    @(negedge clk);
    check("press0_held", 32'(held), 32'h1);
    check("press0_dir", 32'(dir), 32'hE);
    step(1);
    release_btn(4'b0001);
    wait_evt(start + 2, "release0_seen");
    @(negedge clk);
    check("release0_held", 32'(held), 32'h0);
    check("release0_dir", 32'(dir), 32'hE);
    step(1);

    // bounce on channel 1: each level lasts 3 ticks, short of acceptance
    start = events_seen;
    for (int i = 0; i < 6; i++) begin
      btn[1] = ~btn[1];
      step(12);
    end
    step(20);
    @(negedge clk);
    check("bounce_no_pulse", 32'(events_seen - start), 32'h0);
    check("bounce_dir1", 32'(dir[1]), 32'h1);
    step(1);
    press(4'b0010);
    wait_evt(start + 1, "bounce_press_seen");
    release_btn(4'b0010);
    wait_evt(start + 2, "bounce_release_seen");

    // simultaneous presses on channels 2 and 3
    start = events_seen;
    press(4'b1100);
    wait_evt(start + 1, "multi_press_seen");
    @(negedge clk);
    check("multi_held", 32'(held), 32'hC);
    step(1);
    release_btn(4'b1100);
    wait_evt(start + 2, "multi_release_seen");

    // reset while channel 0 is held, button stays down
    start = events_seen;
    press(4'b0001);
    wait_evt(start + 1, "midrst_press_seen");
    @(negedge clk);
    check("midrst_held_before", 32'(held[0]), 32'h1);
    step(1);
    rst = 1'b0;
    step(3);
    @(negedge clk);
    check("midrst_in_reset", 32'({dir, pressed, released, held}), 32'h0000F000);
    dir_m = 4'hF;
    step(1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_dir_init", 32'(dir), 32'hF);
    start = events_seen;
    dir_m = dir_m ^ 4'b0001;
    exp_q.push_back({4'b0001, 4'h0, dir_m});
    step(1);
    wait_evt(start + 1, "midrst_repress_seen");
    @(negedge clk);
    check("midrst_dir_after", 32'(dir), 32'hE);
    step(1);
    release_btn(4'b0001);
    wait_evt(start + 2, "midrst_release_seen");

    // long hold on channel 0: auto-repeat when enabled, single pulse otherwise
    start = events_seen;
    base  = evt_cyc_q.size();
    press(4'b0001);
`ifdef BTN_DIRECTOR_AUTOREPEAT_EN
    repeat (4) exp_q.push_back({4'b0001, 4'h0, dir_m});
`endif
    step(62 * 4);
    check("hold_press_count", 32'(events_seen - start), 32'(NPRESS));
`ifdef BTN_DIRECTOR_AUTOREPEAT_EN
    if (evt_cyc_q.size() >= base + 5) begin
      check("rep_first_gap", 32'(evt_cyc_q[base + 1] - evt_cyc_q[base]), 32'd128);
      for (int i = 2; i < 5; i++)
        check("rep_rate_gap", 32'(evt_cyc_q[base + i] - evt_cyc_q[base + i - 1]), 32'd32);
    end
`endif
    release_btn(4'b0001);
    wait_evt(start + NPRESS + 1, "hold_release_seen");
    @(negedge clk);
    check("hold_dir_once", 32'(dir), 32'(dir_m));

    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
